// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for the sequential ALU execution unit.
// The master drives requests and result acceptance; the slave is the unit.
interface alu_seq_exec_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   modport master (
      output in_valid, alu_ctrl, src_a, src_b, shamt, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, shamt, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit: 1-cycle logic/arith, iterative SLL/SRL.
// Define ALU_SEQ_BARREL_SHIFT_EN to compute shifts combinationally instead.
module alu_seq_exec #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input logic           clk,
   input logic           rst,
   alu_seq_exec_if.slave bus
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_EQ  = 4'b1010;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] op_res;
   logic             op_ill;
   logic             op_shift;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
`else
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] work_nx;

   // dir_q set means logical right shift
   assign work_nx = dir_q ? (work_q >> 1) : (work_q << 1);
`endif

   always_comb begin
      op_res   = '0;
      op_ill   = 1'b0;
      op_shift = 1'b0;
      unique case (1'b1)
         (bus.alu_ctrl == OP_ADD): op_res = bus.src_a + bus.src_b;
         (bus.alu_ctrl == OP_SUB): op_res = bus.src_a - bus.src_b;
         (bus.alu_ctrl == OP_AND): op_res = bus.src_a & bus.src_b;
         (bus.alu_ctrl == OP_OR):  op_res = bus.src_a | bus.src_b;
         (bus.alu_ctrl == OP_SLT):
            op_res = {{(WIDTH-1){1'b0}},
                      ($signed(bus.src_a) < $signed(bus.src_b))};
         (bus.alu_ctrl == OP_EQ):
            op_res = {{(WIDTH-1){1'b0}}, (bus.src_a == bus.src_b)};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
         (bus.alu_ctrl == OP_SLL): op_res = bus.src_b << bus.shamt;
         (bus.alu_ctrl == OP_SRL): op_res = bus.src_b >> bus.shamt;
`else
         // shamt==0 finishes immediately with src_b unchanged
         (bus.alu_ctrl == OP_SLL),
         (bus.alu_ctrl == OP_SRL): begin
            op_res   = bus.src_b;
            op_shift = (bus.shamt != '0);
         end
`endif
         default: op_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
`else
      work_d    = work_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (op_shift) begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
`else
                  work_d  = bus.src_b;
                  cnt_d   = bus.shamt;
                  dir_d   = (bus.alu_ctrl == OP_SRL);
`endif
                  state_d = S_SHIFT;
               end else begin
                  result_d  = op_res;
                  zero_d    = (op_res == '0);
                  illegal_d = op_ill;
                  state_d   = S_DONE;
               end
            end
         end
         S_SHIFT: begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            state_d = S_IDLE;
`else
            work_d = work_nx;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
               result_d  = work_nx;
               zero_d    = (work_nx == '0);
               illegal_d = 1'b0;
               state_d   = S_DONE;
            end
`endif
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

`ifdef ALU_SEQ_BARREL_SHIFT_EN
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         dir_q  <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
      end
   end
`endif

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: driver queues expected responses,
// monitor pops and compares on every output handshake.
module tb_alu_seq_exec;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_EQ  = 4'b1010;
   localparam logic [3:0] OP_BAD = 4'b1111;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   alu_seq_exec_if #(.WIDTH(32), .SHW(5)) bus ();

   alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] q_res[$];
   logic        q_zero[$];
   logic        q_ill[$];
   int          q_lat[$];
   int          q_acc[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input logic [3:0] op, input int sh);
      if (!BARREL && (op == OP_SLL || op == OP_SRL) && sh != 0)
         return sh + 1;
      return 1;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int sh,
                        input logic [31:0] res, input logic ill);
      int guard;
      @(negedge clk);
      bus.alu_ctrl = op;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.shamt    = sh[4:0];
      bus.in_valid = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         chk("accept_timeout", 32'(guard), 32'd0);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      q_res.push_back(res);
      q_zero.push_back(res == 32'd0);
      q_ill.push_back(ill);
      q_lat.push_back(lat_of(op, sh));
      q_acc.push_back(cyc);
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 4'h3;
      bus.src_a    = 32'hDEADBEEF;
      bus.src_b    = 32'hDEADBEEF;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q_res.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_empty", 32'(q_res.size()), 32'd0);
   endtask

   logic vprev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         vprev <= 1'b0;
      end else begin
         if (bus.out_valid && !vprev) begin
            if (q_lat.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               chk("latency", 32'(cyc - q_acc[0] + 1), 32'(q_lat[0]));
            end
         end
         if (bus.out_valid && bus.out_ready && q_res.size() != 0) begin
            chk("result", bus.result, q_res[0]);
            chk("zero", 32'(bus.zero), 32'(q_zero[0]));
            chk("illegal", 32'(bus.illegal), 32'(q_ill[0]));
            void'(q_res.pop_front());
            void'(q_zero.pop_front());
            void'(q_ill.pop_front());
            void'(q_lat.pop_front());
            void'(q_acc.pop_front());
         end
         vprev <= bus.out_valid;
      end
   end

   initial begin
      logic [31:0] held;
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = OP_ADD;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.shamt     = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd1);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      rst = 1'b0;

      // Reset in the middle of a long shift, not scoreboarded
      @(negedge clk);
      bus.alu_ctrl = OP_SLL;
      bus.src_b    = 32'h1;
      bus.shamt    = 5'd20;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_zero", 32'(bus.zero), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      issue(OP_ADD, 32'd3, 32'd4, 0, 32'd7, 1'b0);
      issue(OP_ADD, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b0);
      issue(OP_SUB, 32'd5, 32'd7, 0, 32'hFFFFFFFE, 1'b0);
      issue(OP_SLT, 32'hFFFFFFFE, 32'd1, 0, 32'd1, 1'b0);
      issue(OP_SLT, 32'd1, 32'hFFFFFFFE, 0, 32'd0, 1'b0);
      issue(OP_EQ, 32'h1234, 32'h1234, 0, 32'd1, 1'b0);
      issue(OP_EQ, 32'h1234, 32'h1235, 0, 32'd0, 1'b0);
      issue(OP_SLL, 32'd0, 32'h1, 31, 32'h80000000, 1'b0);
      issue(OP_SRL, 32'd0, 32'h80000000, 4, 32'h08000000, 1'b0);
      issue(OP_SLL, 32'd0, 32'hABCD, 0, 32'hABCD, 1'b0);
      issue(OP_SRL, 32'd0, 32'hF0, 4, 32'hF, 1'b0);
      issue(OP_SLL, 32'd0, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 1'b0);
      issue(OP_SRL, 32'd0, 32'h1, 1, 32'd0, 1'b0);
      issue(OP_BAD, 32'd5, 32'd6, 0, 32'd0, 1'b1);
      issue(OP_AND, 32'hF0F0, 32'hFF00, 0, 32'hF000, 1'b0);
      issue(OP_OR, 32'hF0F0, 32'h0F0F, 0, 32'hFFFF, 1'b0);
      drain();

      // Backpressure: hold DONE for 10 cycles, poke in_valid meanwhile
      bus.out_ready = 1'b0;
      issue(OP_ADD, 32'd10, 32'd20, 0, 32'd30, 1'b0);
      @(negedge clk);
      held = bus.result;
      chk("bp_held_value", held, 32'd30);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.alu_ctrl = OP_SUB;
         bus.src_a    = 32'd1;
         bus.src_b    = 32'd2;
         bus.in_valid = (i % 2 == 0);
         @(negedge clk);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_result", bus.result, held);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_queue_empty", 32'(q_res.size()), 32'd0);

      issue(OP_ADD, 32'd100, 32'd23, 0, 32'd123, 1'b0);
      drain();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
